// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate unit (ROL/SLL/ROR/SRA): one power-of-two barrel stage per clock.
// Optional build macro SHIFT_SKIP_ZERO_EN visits only the stages whose amount bit is set.
//
// state | meaning
// IDLE  | ready for a request, in_ready=1
// SHIFT | applying stage k to the data register
// DONE  | result presented, waiting for out_ready
module shift_seq_unit #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int KW = $clog2(SHW);
  localparam logic [SHW:0] WL = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, stage_res;
  logic [SHW-1:0]   amt_q, amt_d;
  logic [1:0]       op_q, op_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SHW:0]     sh;

  // Single stage network shared by every cycle; distance is 2^k.
  always_comb begin
    sh = {{SHW{1'b0}}, 1'b1} << k_q;
    case (op_q)
      2'b00:   stage_res = (data_q << sh) | (data_q >> (WL - sh));
      2'b01:   stage_res = data_q << sh;
      2'b10:   stage_res = (data_q >> sh) | (data_q << (WL - sh));
      default: stage_res = $unsigned($signed(data_q) >>> sh);
    endcase
  end

`ifdef SHIFT_SKIP_ZERO_EN
  logic          nxt_set;
  logic [KW-1:0] nxt_k, first_k;

  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    nxt_set = 1'b0;
    nxt_k   = '0;
    first_k = '0;
    for (int j = SHW-1; j >= 0; j--) begin
      if (amt_q[j] && (j > int'(k_q))) begin
        nxt_set = 1'b1;
        nxt_k   = KW'(j);
      end
      if (in_amt[j]) first_k = KW'(j);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          amt_d  = in_amt;
          op_d   = in_op;
`ifdef SHIFT_SKIP_ZERO_EN
          k_d     = first_k;
          state_d = (in_amt == '0) ? DONE : SHIFT;
`else
          k_d     = '0;
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (amt_q[k_q]) data_d = stage_res;
`ifdef SHIFT_SKIP_ZERO_EN
        if (nxt_set) k_d = nxt_k;
        else state_d = DONE;
`else
        if (k_q == KW'(SHW-1)) state_d = DONE;
        else k_d = k_q + KW'(1);
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit (WIDTH=16); expected results are hand-computed constants.
module tb_shift_seq_unit;

  localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRA = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shift_seq_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Edges after the accept edge until out_valid is seen.
  function automatic int exp_lat(input logic [3:0] a);
`ifdef SHIFT_SKIP_ZERO_EN
    return $countones(a);
`else
    return 4;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] a, input logic [15:0] exp, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; in_amt = ~a; in_op = ~op;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, ".in_ready_busy"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat(a));
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".out_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_data"}, out_data, exp);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_post"}, out_valid, 0);
    chk({tag, ".in_ready_post"}, in_ready, 1);
  endtask

  initial begin
    int stale;
    #12;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_data", out_data, 16'h0000);
    chk("reset.busy", busy, 0);
    chk("reset.in_ready", in_ready, 1);
    rst_n = 1'b1;

    // out_ready while idle must not disturb anything
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready.out_valid", out_valid, 0);
    chk("idle_ready.in_ready", in_ready, 1);
    out_ready = 1'b0;

    run_op("rol_1234_4", ROL, 16'h1234, 4'd4, 16'h2341, 0);
    run_op("sra_8001_15", SRA, 16'h8001, 4'd15, 16'hFFFF, 0);
    run_op("sll_8001_1", SLL, 16'h8001, 4'd1, 16'h0002, 0);
    run_op("sra_7ff0_4", SRA, 16'h7FF0, 4'd4, 16'h07FF, 0);
    run_op("ror_000f_4", ROR, 16'h000F, 4'd4, 16'hF000, 0);
    run_op("rol_abcd_0", ROL, 16'hABCD, 4'd0, 16'hABCD, 0);
    run_op("sll_abcd_0", SLL, 16'hABCD, 4'd0, 16'hABCD, 0);
    run_op("ror_abcd_0", ROR, 16'hABCD, 4'd0, 16'hABCD, 0);
    run_op("sra_abcd_0", SRA, 16'hABCD, 4'd0, 16'hABCD, 0);
    run_op("rol_00ff_8", ROL, 16'h00FF, 4'd8, 16'hFF00, 0);
    run_op("rol_8001_15", ROL, 16'h8001, 4'd15, 16'hC000, 0);
    run_op("ror_1234_5", ROR, 16'h1234, 4'd5, 16'hA091, 0);
    run_op("sll_00ff_15", SLL, 16'h00FF, 4'd15, 16'h8000, 0);
    run_op("sra_8000_1", SRA, 16'h8000, 4'd1, 16'hC000, 0);

    // backpressure then back-to-back request
    run_op("stall", ROL, 16'h1234, 4'd4, 16'h2341, 5);
    run_op("b2b", ROR, 16'h000F, 4'd4, 16'hF000, 0);

    // reset in the middle of SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234; in_amt = 4'd15; in_op = ROL;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_data", out_data, 16'h0000);
    #4 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale++;
    end
    chk("midrst.no_stale", stale, 0);
    run_op("post_rst_rol", ROL, 16'h0001, 4'd1, 16'h0002, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
